// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: default parameter values,
// the FSM state encoding and a small saturation helper.
package pwm_capture_pkg;

    localparam int DEF_PERIOD_W = 8;
    localparam int DEF_AVG_LOG2 = 2;
    localparam int DEF_TIMEOUT  = 512;

    // State codes kept as plain constants for older code that compares raw bits.
    localparam logic [0:0] STATE_SYNC = 1'b0;  // waiting for the first rising edge
    localparam logic [0:0] STATE_MEAS = 1'b1;  // measuring a PWM period

    typedef enum logic [0:0] {
        SYNC = STATE_SYNC,
        MEAS = STATE_MEAS
    } state_e;

    localparam logic [7:0] SAMPLE_MAX = 8'hFF;

    // Clip a high-time count to the 8-bit sample range.
    function automatic logic [7:0] clip8(input logic [31:0] v);
        return (v > 32'd255) ? SAMPLE_MAX : v[7:0];
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Input conditioning for the PWM capture block: a two-flop synchronizer
// followed by a registered level/rising-edge stage. level and rise are
// aligned, so the cycle flagged by rise already has level = 1. A pwmin
// transition shows up on rise three clocks later.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic sync1;
    logic sync2;

    // Synchronize the asynchronous input and register the edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            level <= sync2;
            rise  <= sync2 & ~level;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: recovers an 8-bit sample from the high time of each PWM
// period. A rising edge closes one period and opens the next; a missing
// edge for TIMEOUT clocks yields a 0/255 sample and raises no_signal.
//
// Optional feature: define PWM_CAPTURE_AVG_EN to average 2^AVG_LOG2
// consecutive period values into each sample (timeout values bypass it).
//
// Output handshake: sample/sample_valid form a valid/ready pair. A transfer
// happens on any cycle with sample_valid && sample_ready. sample is held
// stable while valid and not replaced; a new value that lands while valid
// is high and ready is low overwrites it and pulses overrun for one cycle.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwmin,
    output logic [7:0] sample,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       overrun,
    output logic       no_signal
);

    // Counters must hold TIMEOUT and at least one nominal period.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > PERIOD_W + 1) ?
                           $clog2(TIMEOUT + 1) : PERIOD_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             level;
    logic             rise;
    state_e           state;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;

    logic             timeout_hit;
    logic             meas_stb;
    logic [7:0]       meas_val;
    logic             to_stb;
    logic [7:0]       to_val;
    logic             emit_stb;
    logic [7:0]       emit_val;

    pwm_sync_edge u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pwmin),
        .level (level),
        .rise  (rise)
    );

    // Period values: a closing edge in MEAS gives the clipped high time; a
    // timeout gives full-scale or zero depending on the stuck level. Once
    // no_signal is up, SYNC stays silent until the next rising edge.
    always_comb begin
        timeout_hit = (period_cnt == CNT_LAST) && !rise;
        meas_stb    = (state == MEAS) && rise;
        meas_val    = clip8(32'(high_cnt));
        to_stb      = timeout_hit && ((state == MEAS) || !no_signal);
        to_val      = level ? SAMPLE_MAX : 8'd0;
    end

    // Measurement FSM: period and high-time counters plus no_signal.
    // A rising edge restarts both counters at 1 because the edge cycle is
    // itself a high cycle of the new period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SYNC;
            period_cnt <= '0;
            high_cnt   <= '0;
            no_signal  <= 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    if (rise) begin
                        state      <= MEAS;
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                        no_signal  <= 1'b0;
                    end else if (!no_signal) begin
                        if (timeout_hit) begin
                            period_cnt <= '0;
                            high_cnt   <= '0;
                            no_signal  <= 1'b1;
                        end else if (period_cnt != CNT_MAX) begin
                            period_cnt <= period_cnt + CNT_ONE;
                        end
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                    end else if (timeout_hit) begin
                        state      <= SYNC;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        no_signal  <= 1'b1;
                    end else begin
                        if (period_cnt != CNT_MAX) begin
                            period_cnt <= period_cnt + CNT_ONE;
                        end
                        if (level && (high_cnt != CNT_MAX)) begin
                            high_cnt <= high_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state      <= SYNC;
                    period_cnt <= '0;
                    high_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PWM_CAPTURE_AVG_EN
    localparam int ACC_W = 8 + AVG_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] avg_cnt;
    logic [AVG_LOG2-1:0] avg_cnt_d;

    // Averaging: sum period values and emit the mean when the count wraps;
    // a timeout value goes out at once and restarts the average.
    always_comb begin
        acc_sum   = acc + ACC_W'(meas_val);
        acc_d     = acc;
        avg_cnt_d = avg_cnt;
        emit_stb  = 1'b0;
        emit_val  = 8'd0;
        if (to_stb) begin
            emit_stb  = 1'b1;
            emit_val  = to_val;
            acc_d     = '0;
            avg_cnt_d = '0;
        end else if (meas_stb) begin
            if (avg_cnt == '1) begin
                emit_stb  = 1'b1;
                emit_val  = acc_sum[ACC_W-1:AVG_LOG2];
                acc_d     = '0;
                avg_cnt_d = '0;
            end else begin
                acc_d     = acc_sum;
                avg_cnt_d = avg_cnt + 1'b1;
            end
        end
    end

    // Accumulator and period count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else begin
            acc     <= acc_d;
            avg_cnt <= avg_cnt_d;
        end
    end
`else
    // Direct path: every period value becomes a sample.
    always_comb begin
        emit_stb = to_stb | meas_stb;
        emit_val = to_stb ? to_val : meas_val;
    end

    // AVG_LOG2 only matters when averaging is built in.
    if (AVG_LOG2 < 1) begin : g_avg_log2_unused
    end
`endif

    // Output register: load new samples, clear valid on a transfer, flag
    // overwrites of a sample nobody accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample       <= 8'd0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= emit_stb && sample_valid && !sample_ready;
            if (emit_stb) begin
                sample       <= emit_val;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture. Inputs change 1 time unit after a rising
// clock edge; the main flow checks at the same point, the scoreboard checks
// transfers on the falling edge. Expected samples are queued by hand.
`timescale 1ns/1ps
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwmin;
    logic       sample_ready;
    logic [7:0] sample;
    logic       sample_valid;
    logic       overrun;
    logic       no_signal;

    int tests_run    = 0;
    int tests_failed = 0;
    int hs_cnt       = 0;
    int ovr_cnt      = 0;

    logic [8:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #(1000000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    pwm_capture dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwmin        (pwmin),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .no_signal    (no_signal)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && sample_valid && sample_ready) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 9'h100;  // no sample expected: cannot match
            hs_cnt++;
            check("sample", int'(sample), int'(e));
        end
        if (rst_n && overrun) ovr_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic v, input int n);
        pwmin = v;
        tick(n);
    endtask

    task automatic pwm_period(input int high, input int total);
        hold(1'b1, high);
        hold(1'b0, total - high);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        pwmin        = 1'b0;
        sample_ready = 1'b1;
        tick(4);
        check("reset_sample", sample, 0);
        check("reset_valid", sample_valid, 0);
        check("reset_overrun", overrun, 0);
        check("reset_no_signal", no_signal, 0);
        rst_n = 1'b1;
        tick(10);

`ifdef PWM_CAPTURE_AVG_EN
        // Averaging: 10,20,30,40 -> one sample of 25 on the 5th edge.
        exp_q.push_back(9'd25);
        pwm_period(10, 256);
        pwm_period(20, 256);
        pwm_period(30, 256);
        check("avg_no_early_sample", hs_cnt, 0);
        pwm_period(40, 256);
        hold(1'b1, 10);
        check("avg_one_sample", hs_cnt, 1);
        check("avg_sample_value", sample, 25);
        check("avg_no_signal", no_signal, 0);
        hold(1'b0, 20);
`else
        // Steady 64/256 PWM: first edge arms, each later edge gives 64,
        // then the line stays low and times out with a 0 sample.
        repeat (3) exp_q.push_back(9'd64);
        exp_q.push_back(9'd0);
        repeat (3) pwm_period(64, 256);
        hold(1'b1, 64);
        hold(1'b0, 446);
        check("low_no_signal_before_timeout", no_signal, 0);
        check("steady_three_samples", hs_cnt, 3);
        hold(1'b0, 10);
        check("low_no_signal_after_timeout", no_signal, 1);
        check("low_timeout_sample", sample, 0);
        check("low_timeout_count", hs_cnt, 4);
        hold(1'b0, 80);
        check("low_silent_in_sync", hs_cnt, 4);

        // A rising edge re-arms: no_signal drops, no sample.
        hold(1'b1, 10);
        check("rearm_no_signal", no_signal, 0);
        check("rearm_no_sample_valid", sample_valid, 0);
        check("rearm_no_sample", hs_cnt, 4);
        hold(1'b1, 54);
        hold(1'b0, 192);

        // Held high: the edge closes a 64 period, then timeout gives 255.
        exp_q.push_back(9'd64);
        exp_q.push_back(9'd255);
        hold(1'b1, 510);
        check("high_no_signal_before_timeout", no_signal, 0);
        check("high_period_sample", hs_cnt, 5);
        hold(1'b1, 10);
        check("high_no_signal_after_timeout", no_signal, 1);
        check("high_timeout_sample", sample, 255);
        check("high_timeout_count", hs_cnt, 6);
        hold(1'b1, 80);
        hold(1'b0, 20);

        // Consumer stalls across two periods: 100 then 200 overwrites it.
        sample_ready = 1'b0;
        ovr_cnt      = 0;
        pwm_period(100, 256);
        hold(1'b1, 10);
        check("stall_first_sample", sample, 100);
        check("stall_first_valid", sample_valid, 1);
        check("stall_no_overrun_yet", ovr_cnt, 0);
        hold(1'b1, 190);
        hold(1'b0, 56);
        hold(1'b1, 10);
        check("stall_overrun_once", ovr_cnt, 1);
        check("stall_sample_overwritten", sample, 200);
        check("stall_valid_held", sample_valid, 1);
        check("stall_no_transfer", hs_cnt, 6);

        // Reset in the middle of a high phase (high_cnt near 50).
        hold(1'b1, 42);
        rst_n = 1'b0;
        pwmin = 1'b0;
        tick(1);
        check("midreset_sample", sample, 0);
        check("midreset_valid", sample_valid, 0);
        check("midreset_overrun", overrun, 0);
        check("midreset_no_signal", no_signal, 0);
        tick(3);
        rst_n        = 1'b1;
        sample_ready = 1'b1;
        tick(20);

        // First post-reset edge only arms; the next ones give 80 and 90.
        exp_q.push_back(9'd80);
        exp_q.push_back(9'd90);
        hold(1'b1, 10);
        check("post_reset_arm_no_sample", hs_cnt, 6);
        check("post_reset_arm_valid", sample_valid, 0);
        hold(1'b1, 70);
        hold(1'b0, 176);
        pwm_period(90, 256);
        hold(1'b1, 10);
        hold(1'b0, 20);
        check("post_reset_samples", hs_cnt, 8);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
